// File: rtl/bram_port_arbiter_if.sv
// Requester-side and BRAM-side signals of the shared BRAM port arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the BRAM.
interface bram_port_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic [ADDR_WIDTH-1:0]         bram_addr;
    logic                          bram_we;
    logic [DATA_WIDTH-1:0]         bram_wdata;
    logic [DATA_WIDTH-1:0]         bram_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, bram_rdata,
        output req_ready, rsp_valid, rsp_data, bram_addr, bram_we, bram_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, bram_rdata,
        input  req_ready, rsp_valid, rsp_data, bram_addr, bram_we, bram_wdata
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter with bounded bursts sharing one single-port BRAM among NUM_REQ
// requesters; read data is steered back one cycle after the read is accepted.
module bram_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4
) (
    input logic                clk,
    input logic                rst_n,
    bram_port_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BURST_MAX);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] rd_pend_q, rd_pend_d;

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi] = bus.req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    logic [IDX_W-1:0]   start_idx;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    logic [NUM_REQ-1:0] grant_oh;

    // Circular scan from start_idx; the owner of an unfinished burst is scanned first.
    always_comb begin
        logic [IDX_W-1:0] cand;
        cand      = '0;
        start_idx = (cnt_q < CNT_MAX) ? last_q
                  : ((last_q == IDX_LAST) ? '0 : last_q + 1'b1);
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(start_idx) + k) % NUM_REQ);
            if (!grant_any && bus.req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        // Nothing is granted or driven to the BRAM while reset is held.
        if (!rst_n) begin
            grant_any = 1'b0;
        end
        grant_oh = '0;
        if (grant_any) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        last_d    = last_q;
        cnt_d     = cnt_q;
        rd_pend_d = '0;
        if (grant_any) begin
            last_d = grant_idx;
            if (grant_idx == last_q) begin
                cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
            end else begin
                cnt_d = CNT_W'(1);
            end
            if (!bus.req_we[grant_idx]) begin
                rd_pend_d = grant_oh;
            end
        end else begin
            // An idle cycle ends the burst so the next search begins past the last grantee.
            cnt_d = CNT_MAX;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q    <= IDX_LAST;
            cnt_q     <= CNT_MAX;
            rd_pend_q <= '0;
        end else begin
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    assign bus.req_ready  = grant_oh;
    assign bus.bram_we    = grant_any & bus.req_we[grant_idx];
    assign bus.bram_addr  = grant_any ? addr_arr[grant_idx]  : '0;
    assign bus.bram_wdata = grant_any ? wdata_arr[grant_idx] : '0;
    assign bus.rsp_valid  = rd_pend_q;
    assign bus.rsp_data   = bus.bram_rdata;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench: stimulus pushes expected grants and read responses into queues,
// a negedge monitor pops and compares them against two arbiter instances.
module tb_bram_port_arbiter;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    bram_port_arbiter_if #(.NUM_REQ(4), .ADDR_WIDTH(4), .DATA_WIDTH(8)) if4 ();
    bram_port_arbiter_if #(.NUM_REQ(4), .ADDR_WIDTH(4), .DATA_WIDTH(8)) if1 ();

    bram_port_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(4), .DATA_WIDTH(8), .BURST_MAX(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(if4)
    );
    bram_port_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(4), .DATA_WIDTH(8), .BURST_MAX(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1)
    );

    // BRAM behind dut4: one-cycle registered read
    logic [7:0] bram_mem [16] = '{default: 8'h00};
    logic [7:0] bram_rd = 8'h00;
    always @(posedge clk) begin
        if (if4.bram_we) bram_mem[if4.bram_addr] <= if4.bram_wdata;
        bram_rd <= bram_mem[if4.bram_addr];
    end
    assign if4.bram_rdata = bram_rd;
    assign if1.bram_rdata = 8'h00;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [3:0] ready;
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
    } gexp_t;

    typedef struct {
        int         due;
        logic [3:0] oh;
        logic [7:0] data;
    } rexp_t;

    gexp_t gq4[$];
    gexp_t gq1[$];
    rexp_t rq[$];
    logic [7:0] ref_mem [16] = '{default: 8'h00};

    int checks = 0;
    int errors = 0;
    bit done   = 1'b0;

    function automatic gexp_t mk_exp(int g, int due, logic [3:0] we, logic [15:0] a, logic [31:0] wd);
        gexp_t e;
        e.due = due;
        if (g < 0) begin
            e.ready = 4'b0000; e.we = 1'b0; e.addr = 4'h0; e.wdata = 8'h00;
        end else begin
            e.ready = 4'b0001 << g;
            e.we    = we[g];
            e.addr  = a[g*4 +: 4];
            e.wdata = wd[g*8 +: 8];
        end
        return e;
    endfunction

    // sel picks which arbiter receives the request pattern; the other one idles.
    task automatic drive(input int sel, input bit rst, input logic [3:0] v, input logic [3:0] we,
                         input logic [15:0] a, input logic [31:0] wd, input int g, input bit want_rsp);
        rexp_t r;
        @(posedge clk);
        #1;
        rst_n = !rst;
        if4.req_valid = (sel == 0) ? v  : 4'h0;
        if4.req_we    = (sel == 0) ? we : 4'h0;
        if4.req_addr  = (sel == 0) ? a  : 16'h0;
        if4.req_wdata = (sel == 0) ? wd : 32'h0;
        if1.req_valid = (sel == 1) ? v  : 4'h0;
        if1.req_we    = (sel == 1) ? we : 4'h0;
        if1.req_addr  = (sel == 1) ? a  : 16'h0;
        if1.req_wdata = (sel == 1) ? wd : 32'h0;
        gq4.push_back(mk_exp((sel == 0 && !rst) ? g : -1, cyc, we, a, wd));
        gq1.push_back(mk_exp((sel == 1 && !rst) ? g : -1, cyc, we, a, wd));
        if (sel == 0 && !rst && g >= 0) begin
            if (we[g]) begin
                ref_mem[a[g*4 +: 4]] = wd[g*8 +: 8];
            end else if (want_rsp) begin
                r.due  = cyc + 1;
                r.oh   = 4'b0001 << g;
                r.data = ref_mem[a[g*4 +: 4]];
                rq.push_back(r);
            end
        end
    endtask

    function automatic void cmp_grant(string nm, gexp_t e, logic [3:0] rdy, logic we,
                                      logic [3:0] a, logic [7:0] wd);
        checks++;
        if (rdy !== e.ready || we !== e.we || a !== e.addr || wd !== e.wdata) begin
            errors++;
            $display("FAIL %s cyc %0d: got ready=%b we=%b addr=%h wdata=%h, want ready=%b we=%b addr=%h wdata=%h",
                     nm, cyc, rdy, we, a, wd, e.ready, e.we, e.addr, e.wdata);
        end
    endfunction

    always @(negedge clk) begin
        gexp_t e;
        rexp_t r;
        if (gq4.size() > 0 && gq4[0].due == cyc) begin
            e = gq4.pop_front();
            cmp_grant("grant_b4", e, if4.req_ready, if4.bram_we, if4.bram_addr, if4.bram_wdata);
        end
        if (gq1.size() > 0 && gq1[0].due == cyc) begin
            e = gq1.pop_front();
            cmp_grant("grant_b1", e, if1.req_ready, if1.bram_we, if1.bram_addr, if1.bram_wdata);
        end
        if (!rst_n) begin
            checks++;
            if (if4.rsp_valid !== 4'h0) begin
                errors++;
                $display("FAIL rsp_in_reset cyc %0d: got rsp_valid=%b, want 0000", cyc, if4.rsp_valid);
            end
        end else if (if4.rsp_valid !== 4'h0) begin
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected cyc %0d: got rsp_valid=%b data=%h, want no rsp",
                         cyc, if4.rsp_valid, if4.rsp_data);
            end else begin
                r = rq.pop_front();
                if (r.due != cyc || r.oh !== if4.rsp_valid || r.data !== if4.rsp_data) begin
                    errors++;
                    $display("FAIL rsp cyc %0d: got rsp_valid=%b data=%h, want rsp_valid=%b data=%h at cyc %0d",
                             cyc, if4.rsp_valid, if4.rsp_data, r.oh, r.data, r.due);
                end
            end
        end else if (rq.size() > 0 && rq[0].due <= cyc) begin
            checks++;
            errors++;
            r = rq.pop_front();
            $display("FAIL rsp_missing cyc %0d: got rsp_valid=0000, want rsp_valid=%b data=%h",
                     cyc, r.oh, r.data);
        end
        if (done) begin
            checks++;
            if (rq.size() != 0 || gq4.size() != 0 || gq1.size() != 0) begin
                errors++;
                $display("FAIL drain: got pending rsp=%0d grant_b4=%0d grant_b1=%0d, want 0 0 0",
                         rq.size(), gq4.size(), gq1.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        if4.req_valid = '0; if4.req_we = '0; if4.req_addr = '0; if4.req_wdata = '0;
        if1.req_valid = '0; if1.req_we = '0; if1.req_addr = '0; if1.req_wdata = '0;

        // reset, nothing granted
        drive(0, 1, 4'h0, 4'h0, 16'h0, 32'h0, -1, 0);
        drive(0, 1, 4'hF, 4'h0, 16'h0, 32'h0, -1, 0);

        // pure round robin (BURST_MAX=1), all requesters writing
        for (int i = 0; i < 8; i++)
            drive(1, 0, 4'hF, 4'hF, 16'h3210, 32'hDDCCBBAA, i % 4, 0);
        drive(0, 0, 4'h0, 4'h0, 16'h0, 32'h0, -1, 0);

        // bursts of 4 (BURST_MAX=4), all requesters reading their own index as address
        for (int i = 0; i < 16; i++)
            drive(0, 0, 4'hF, 4'h0, 16'h3210, 32'h0, i / 4, 1);
        drive(0, 0, 4'h0, 4'h0, 16'h0, 32'h0, -1, 0);

        // write A5 to addr 3 then read it back
        drive(0, 0, 4'b0001, 4'b0001, 16'h0003, 32'h000000A5, 0, 1);
        drive(0, 0, 4'b0001, 4'b0000, 16'h0003, 32'h0, 0, 1);
        drive(0, 0, 4'h0, 4'h0, 16'h0, 32'h0, -1, 0);

        // req2 burst interrupted by dropping valid; req3 restarts its count
        drive(0, 0, 4'b1101, 4'hF, 16'h7605, 32'h73620050, 2, 1);
        drive(0, 0, 4'b1101, 4'hF, 16'h7605, 32'h73620050, 2, 1);
        drive(0, 0, 4'b1001, 4'hF, 16'h7605, 32'h73620050, 3, 1);
        drive(0, 0, 4'b1001, 4'hF, 16'h7605, 32'h73620050, 3, 1);
        drive(0, 0, 4'b1001, 4'hF, 16'h7605, 32'h73620050, 3, 1);
        drive(0, 0, 4'b1001, 4'hF, 16'h7605, 32'h73620050, 3, 1);
        drive(0, 0, 4'b1001, 4'hF, 16'h7605, 32'h73620050, 0, 1);
        drive(0, 0, 4'h0, 4'h0, 16'h0, 32'h0, -1, 0);
        drive(0, 0, 4'b0100, 4'hF, 16'h7605, 32'h73620050, 2, 1);
        drive(0, 0, 4'b0010, 4'h0, 16'h0060, 32'h0, 1, 1);

        // read by req1, then reset before its response is delivered
        drive(0, 0, 4'b0010, 4'h0, 16'h0070, 32'h0, 1, 0);
        drive(0, 1, 4'b0011, 4'h0, 16'h0073, 32'h0, -1, 0);
        drive(0, 1, 4'b0011, 4'h0, 16'h0073, 32'h0, -1, 0);
        drive(0, 0, 4'b0011, 4'h0, 16'h0073, 32'h0, 0, 1);
        drive(0, 0, 4'b0010, 4'h0, 16'h0073, 32'h0, 1, 1);

        // mixed reads and writes, including write-then-read of the same address
        drive(0, 0, 4'b1111, 4'b0101, 16'h5999, 32'h00220099, 1, 1);
        drive(0, 0, 4'b1101, 4'b0101, 16'h5999, 32'h00220099, 2, 1);
        drive(0, 0, 4'b1011, 4'b0101, 16'h5999, 32'h00220099, 3, 1);
        drive(0, 0, 4'b0011, 4'b0101, 16'h5999, 32'h00220099, 0, 1);
        drive(0, 0, 4'b0010, 4'b0101, 16'h5999, 32'h00220099, 1, 1);
        drive(0, 0, 4'h0, 4'h0, 16'h0, 32'h0, -1, 0);
        drive(0, 0, 4'h0, 4'h0, 16'h0, 32'h0, -1, 0);

        @(posedge clk);
        #1;
        done = 1'b1;
    end
endmodule
